instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that reads program words out of the vector processor's instruction memory. It drives the memory's read address, absorbs the memory's one-cycle synchronous read latency, and presents instructions with their PC to the decoder over a valid/ready stream. It sits between the instruction memory read port and the decode stage. It also handles start, branch redirect and halt from the control path.

## Interface
- `INSTR_WIDTH`, default 32: instruction word width; must match the instruction memory.
- `DEPTH`, default 256: instruction memory depth in words; must be a power of two. `ADDR_W = $clog2(DEPTH)` is derived internally.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start`  in  1: one-cycle pulse; begin fetching at `start_pc`. Honoured only in IDLE.
- `start_pc`  in  ADDR_W: first fetch address.
- `redirect_valid`  in  1: branch/jump taken; restart fetch at `redirect_pc`. Honoured only in RUN.
- `redirect_pc`  in  ADDR_W: redirect target.
- `halt`  in  1: stop fetching and flush. Honoured only in RUN.
- `mem_rd_addr`  out  ADDR_W: read address to instruction memory; equals the internal PC register.
- `mem_rd_data`  in  INSTR_WIDTH: memory read data, valid the cycle after an address is presented.
- `instr_valid`  out  1: `instr_data`/`instr_pc` hold a valid instruction.
- `instr_ready`  in  1: decoder accepts; a transfer occurs when valid and ready are both high.
- `instr_data`  out  INSTR_WIDTH: instruction word.
- `instr_pc`  out  ADDR_W: address the word was fetched from.
- `busy`  out  1: high in RUN.

## Operation
- States:
  - IDLE → RUN on `start`; `pc <= start_pc`.
  - RUN → IDLE on `halt`. The buffer is flushed and in-flight reads are dropped.
- Reset values: state IDLE; pc 0, so `mem_rd_addr` = 0; `instr_valid` 0, `instr_data` 0, `instr_pc` 0, `busy` 0; buffer empty; no read in flight.
- Issue:
  - In RUN, a read is issued in a cycle when `count + inflight - pop < 2`, where count = buffer occupancy (0..2), inflight = 1 if the previous cycle issued, and pop = transfer this cycle.
  - On issue: the in-flight flag is set for the next cycle with tag pc, and `pc <= pc + 1`.
  - pc wraps modulo DEPTH: DEPTH-1 → 0.
- Capture: when a tagged read is in flight, `mem_rd_data` and its pc are written into the 2-entry output FIFO at the end of that cycle.
- Output: `instr_valid`/`instr_data`/`instr_pc` come from the FIFO head. They hold stable while `instr_valid=1` and `instr_ready=0`.
- Invariant: no instruction is lost or duplicated under backpressure. Occupancy never exceeds 2.
- Redirect in cycle R:
  - A transfer that occurs in R completes normally.
  - All other FIFO entries are cleared.
  - The read returning in R and the read issued in R are both discarded.
  - `pc <= redirect_pc`.
- Priority: `rst` > `halt` > `redirect_valid` > normal issue.
  - `start` in RUN, and `redirect_valid`/`halt` in IDLE, are ignored.
- `busy = (state == RUN)`.

## Timing
- Issue at cycle N → data on `mem_rd_data` in N+1 → `instr_valid` from N+2. Fetch latency is 2 cycles.
- `start` at cycle S: first issue in S+1 (`mem_rd_addr` = start_pc); first `instr_valid` in S+3.
- Throughput is 1 instruction/cycle with `instr_ready` held high.
- Redirect at R: `instr_valid` is 0 in R+1 and R+2. First redirected instruction is valid in R+3.
- Halt at H: `busy` and `instr_valid` are 0 from H+1, and no further issue.
- `rst` asserted mid-stream: all outputs return to reset values in the next cycle.
- Backpressure: `instr_ready` low at most fills 2 entries; issue stops until a pop.

## Test plan
- Reset: hold `rst` 3 cycles with random inputs → `busy`=0, `instr_valid`=0, `mem_rd_addr`=0, `instr_data`=0, `instr_pc`=0.
- Streaming: memory preloaded with mem[i]=0xA0000000+i; `start` with `start_pc`=0x10, `instr_ready`=1 → `mem_rd_addr`=0x10 at S+1; `instr_valid` at S+3 with 0xA0000010/pc 0x10; then 0x11, 0x12, … one per cycle.
- Backpressure: `instr_ready` low for 5 cycles mid-stream → outputs held stable; `mem_rd_addr` stalls; after release the sequence continues with no gap, loss or duplicate.
- Redirect: `redirect_valid` with `redirect_pc`=0x40 while streaming from 0x20 → no old-path words after cycle R; next `instr_pc`=0x40 at R+3, then 0x41.
- Wrap: `start_pc`=0xFE → `instr_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- Halt priority: `halt` and `redirect_valid` in the same cycle mid-stream → `busy`=0 and `instr_valid`=0 next cycle, no further issue; a following `start` at 0x05 restarts cleanly with pc 0x05.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the instruction memory read port, absorbs its
// one-cycle read latency and streams {instr, pc} to decode through a 2-entry FIFO.
module instr_fetch #(
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   start_pc,
  input  logic                       redirect_valid,
  input  logic [$clog2(DEPTH)-1:0]   redirect_pc,
  input  logic                       halt,
  output logic [$clog2(DEPTH)-1:0]   mem_rd_addr,
  input  logic [INSTR_WIDTH-1:0]     mem_rd_data,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_WIDTH-1:0]     instr_data,
  output logic [$clog2(DEPTH)-1:0]   instr_pc,
  output logic                       busy
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // p0: fetch PC / read address; p1: read in flight; p2: output FIFO
  logic [ADDR_W-1:0]      pc_p0, pc_nxt;
  logic                   issue_p0;
  logic                   vld_p1;
  logic [ADDR_W-1:0]      rd_pc_p1;
  logic [1:0]             cnt_p2;
  logic [INSTR_WIDTH-1:0] fifo_data_p2 [2];
  logic [ADDR_W-1:0]      fifo_pc_p2   [2];

  logic                   pop;
  logic                   push;
  logic                   flush;
  logic                   wr_idx;
  logic [2:0]             occ;

  // DEPTH is a power of two, so natural ADDR_W-bit overflow gives the wrap.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  assign pop = (cnt_p2 != 2'd0) && instr_ready;

  // Occupancy the FIFO would reach if nothing new were issued this cycle.
  assign occ = 3'(cnt_p2) + 3'(vld_p1) - 3'(pop);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    issue_p0  = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = start_pc;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = IDLE;
          flush     = 1'b1;
        end else if (redirect_valid) begin
          flush  = 1'b1;
          pc_nxt = redirect_pc;
        end else begin
          push = vld_p1;
          if (occ < 3'd2) begin
            issue_p0 = 1'b1;
            pc_nxt   = pc_inc(pc_p0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slot the captured word lands in, after this cycle's pop has been applied.
  assign wr_idx = (cnt_p2 == 2'd2) || ((cnt_p2 == 2'd1) && !pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_p0  <= '0;
      vld_p1 <= 1'b0;
      cnt_p2 <= 2'd0;
    end else begin
      state  <= state_nxt;
      pc_p0  <= pc_nxt;
      vld_p1 <= issue_p0;
      if (flush) begin
        cnt_p2 <= 2'd0;
      end else begin
        cnt_p2 <= cnt_p2 - 2'(pop) + 2'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_p0) begin
      rd_pc_p1 <= pc_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && (cnt_p2 == 2'd2)) begin
      fifo_data_p2[0] <= fifo_data_p2[1];
      fifo_pc_p2[0]   <= fifo_pc_p2[1];
    end
    if (push) begin
      fifo_data_p2[wr_idx] <= mem_rd_data;
      fifo_pc_p2[wr_idx]   <= rd_pc_p1;
    end
  end

  // Payload is masked while empty so it reads as zero out of reset and after flush.
  assign mem_rd_addr = pc_p0;
  assign instr_valid = (cnt_p2 != 2'd0);
  assign instr_data  = instr_valid ? fifo_data_p2[0] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_p2[0]   : '0;
  assign busy        = (state == RUN);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based stream model checked every cycle, directed
// scenarios with literal expectations, then randomized control and backpressure.
module tb_instr_fetch;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_pc;
  logic          busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  logic [31:0] mem [DEPTH];

  // Reference model: fetch state as plain integers and an SV queue of pcs.
  int m_pc   = 0;
  bit m_run  = 0;
  bit m_infl = 0;
  int m_tag  = 0;
  int q[$];

  instr_fetch #(.INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    automatic bit pop = (q.size() > 0) && instr_ready;
    automatic int occ = q.size() + int'(m_infl) - int'(pop);
    if (rst) begin
      m_run = 0; m_pc = 0; m_infl = 0; q.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_pc = start_pc;
      end
    end else if (halt) begin
      m_run = 0; m_infl = 0; q.delete();
    end else if (redirect_valid) begin
      m_infl = 0; q.delete(); m_pc = redirect_pc;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back(m_tag);
      if (occ < 2) begin
        m_infl = 1; m_tag = m_pc; m_pc = (m_pc + 1) % DEPTH;
      end else begin
        m_infl = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_run));
      chk("mem_rd_addr", 32'(mem_rd_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("instr_pc", 32'(instr_pc), 32'(q[0]));
        chk("instr_data", instr_data, 32'hA000_0000 + 32'(q[0]));
      end
      if (q.size() > 2) chk("model_occupancy", 32'(q.size()), 32'd2);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] pc);
    start = 1; start_pc = pc;
    step(1);
    start = 0;
    chk("start_addr", 32'(mem_rd_addr), 32'(pc));
    step(2);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", 32'(instr_pc), 32'(pc));
    chk("first_data", instr_data, 32'hA000_0000 + 32'(pc));
  endtask

  initial begin
    logic [AW-1:0] held;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst = 1; instr_ready = 1; start = 0; halt = 0; redirect_valid = 0;
    start_pc = 0; redirect_pc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      start = 1'($urandom); halt = 1'($urandom); redirect_valid = 1'($urandom);
      start_pc = AW'($urandom); redirect_pc = AW'($urandom); instr_ready = 1'($urandom);
    end
    step(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_data", instr_data, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    rst = 0; start = 0; halt = 0; redirect_valid = 0; instr_ready = 1;
    chk_en = 1;
    step(2);

    // Streaming from 0x10, then 5 cycles of backpressure
    do_start(8'h10);
    step(1); chk("stream_pc1", 32'(instr_pc), 32'h11);
    step(1); chk("stream_pc2", 32'(instr_pc), 32'h12);
    chk("stream_data2", instr_data, 32'hA000_0012);
    instr_ready = 0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_hold_pc", 32'(instr_pc), 32'h12);
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      if (i == 1) held = mem_rd_addr;
      if (i == 4) chk("bp_addr_stall", 32'(mem_rd_addr), 32'(held));
    end
    instr_ready = 1;
    step(1); chk("bp_resume_pc", 32'(instr_pc), 32'h13);
    step(1); chk("bp_resume_pc2", 32'(instr_pc), 32'h14);
    halt = 1; step(1); halt = 0;
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);

    // Redirect while streaming from 0x20
    do_start(8'h20);
    step(3);
    redirect_valid = 1; redirect_pc = 8'h40;
    step(1); redirect_valid = 0;
    chk("redir_r1_valid", 32'(instr_valid), 32'd0);
    step(1); chk("redir_r2_valid", 32'(instr_valid), 32'd0);
    step(1); chk("redir_r3_pc", 32'(instr_pc), 32'h40);
    chk("redir_r3_valid", 32'(instr_valid), 32'd1);
    step(1); chk("redir_r4_pc", 32'(instr_pc), 32'h41);
    halt = 1; step(1); halt = 0;

    // Wrap around the top of memory
    do_start(8'hFE);
    step(1); chk("wrap_pc1", 32'(instr_pc), 32'hFF);
    step(1); chk("wrap_pc2", 32'(instr_pc), 32'h00);
    step(1); chk("wrap_pc3", 32'(instr_pc), 32'h01);

    // Halt wins over a simultaneous redirect
    halt = 1; redirect_valid = 1; redirect_pc = 8'h80;
    step(1); halt = 0; redirect_valid = 0;
    chk("hp_busy", 32'(busy), 32'd0);
    chk("hp_valid", 32'(instr_valid), 32'd0);
    held = mem_rd_addr;
    step(3);
    chk("hp_no_issue", 32'(mem_rd_addr), 32'(held));
    do_start(8'h05);

    // Randomized control traffic and backpressure
    for (int i = 0; i < 4000; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      start          = ($urandom_range(0, 3) == 0);
      start_pc       = AW'($urandom);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = AW'($urandom);
      halt           = ($urandom_range(0, 63) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 0; start = 0; halt = 0; redirect_valid = 0; instr_ready = 1;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
